// File: rtl/multilayer_canvas_if.sv
// Brush-stamp request channel between the cursor/colour logic and the canvas engine.
// A stamp transfers on a rising clock edge where brush_valid and brush_ready are both high;
// the master holds every brush_* field stable while brush_valid is high and not yet accepted.
interface multilayer_canvas_if #(
  parameter int NUM_LAYERS = 3,
  parameter int COLOR_W    = 3
);
  logic                  brush_valid;
  logic                  brush_ready;
  logic [9:0]            brush_x;
  logic [9:0]            brush_y;
  logic [1:0]            brush_size;
  logic [COLOR_W-1:0]    brush_color;
  logic [NUM_LAYERS-1:0] brush_layer_mask;

  modport master (
    output brush_valid, brush_x, brush_y, brush_size, brush_color, brush_layer_mask,
    input  brush_ready
  );

  modport slave (
    input  brush_valid, brush_x, brush_y, brush_size, brush_color, brush_layer_mask,
    output brush_ready
  );
endinterface

// File: rtl/multilayer_canvas.sv
// Multi-layer downscaled paint canvas: brush/clear write FSM plus a 3-stage
// scan pipeline that composites visible layers into rgb.
module multilayer_canvas #(
  parameter int                NUM_LAYERS = 3,
  parameter int                COLOR_W    = 3,
  parameter int                H_RES      = 640,
  parameter int                V_RES      = 480,
  parameter int                SCALE      = 2,
  parameter logic [COLOR_W-1:0] BG        = '1
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  multilayer_canvas_if.slave    brush,
  input  logic                  video_on,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  clear_req,
  input  logic [NUM_LAYERS-1:0] clear_layer_mask,
  input  logic [NUM_LAYERS-1:0] show_mask,
  output logic                  busy,
  output logic                  op_done,
  output logic [COLOR_W-1:0]    rgb,
  output logic [1:0]            state_dbg
);
  localparam int CW     = H_RES / SCALE;
  localparam int CH     = V_RES / SCALE;
  localparam int DEPTH  = CW * CH;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SH     = $clog2(SCALE);

  typedef enum logic [1:0] {ST_CLEAR = 2'd0, ST_IDLE = 2'd1, ST_PAINT = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [9:0]            cx_q, cx_d, cy_q, cy_d;
  logic [1:0]            size_q, size_d;
  logic [COLOR_W-1:0]    color_q, color_d;
  logic [2:0]            dx_q, dx_d, dy_q, dy_d;
  logic                  op_done_q, op_done_d;

  logic [NUM_LAYERS-1:0] we;
  logic [ADDR_W-1:0]     waddr;
  logic [COLOR_W-1:0]    wdata;
  logic [10:0]           px, py;
  logic [2:0]            last_idx;

  assign busy              = (state_q != ST_IDLE);
  assign op_done           = op_done_q;
  assign state_dbg         = state_q;
  assign brush.brush_ready = (state_q == ST_IDLE) && !clear_req && !reset;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    size_d    = size_q;
    color_d   = color_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    op_done_d = 1'b0;
    we        = '0;
    waddr     = '0;
    wdata     = BG;
    px        = {1'b0, cx_q} + 11'(dx_q);
    py        = {1'b0, cy_q} + 11'(dy_q);
    last_idx  = 3'((4'd1 << size_q) - 4'd1);
    unique case (state_q)
      ST_CLEAR: begin
        we    = mask_q;
        waddr = cnt_q;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          op_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          mask_d  = clear_layer_mask;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end else if (brush.brush_valid) begin
          cx_d    = brush.brush_x >> SH;
          cy_d    = brush.brush_y >> SH;
          size_d  = brush.brush_size;
          color_d = brush.brush_color;
          mask_d  = brush.brush_layer_mask;
          dx_d    = '0;
          dy_d    = '0;
          state_d = ST_PAINT;
        end
      end
      ST_PAINT: begin
        wdata = color_q;
        // Off-canvas pixels still burn their cycle so stamp duration stays side^2.
        if (px < 11'(CW) && py < 11'(CH)) begin
          we    = mask_q;
          waddr = ADDR_W'(32'(py) * CW + 32'(px));
        end
        if (dx_q == last_idx) begin
          dx_d = '0;
          if (dy_q == last_idx) begin
            state_d   = ST_IDLE;
            op_done_d = 1'b1;
          end else begin
            dy_d = dy_q + 3'd1;
          end
        end else begin
          dx_d = dx_q + 3'd1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      mask_q    <= '1;
      cx_q      <= '0;
      cy_q      <= '0;
      size_q    <= '0;
      color_q   <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      op_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      size_q    <= size_d;
      color_q   <= color_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      op_done_q <= op_done_d;
    end
  end

  // Scan pipeline: S0 address/controls, S1 BRAM read, S2 composite.
  logic [ADDR_W-1:0]                   raddr_q, raddr_d;
  logic                                von0_q, von1_q;
  logic [NUM_LAYERS-1:0]               show0_q, show1_q;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0]  rd_all;
  logic [COLOR_W-1:0]                  rgb_q, rgb_d;
  logic                                found;

  always_comb begin
    raddr_d = '0;
    if (video_on) raddr_d = ADDR_W'((32'(y) >> SH) * CW + (32'(x) >> SH));
  end

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    logic [COLOR_W-1:0] mem [DEPTH];
    logic [COLOR_W-1:0] rd_q;
    // Read and write share one edge, so a colliding scan read returns the old word.
    always_ff @(posedge clk_100MHz) begin
      if (we[l]) mem[waddr] <= wdata;
      rd_q <= mem[raddr_q];
    end
    assign rd_all[l] = rd_q;
  end

  always_comb begin
    rgb_d = BG;
    found = 1'b0;
    for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
      if (!found && show1_q[l] && rd_all[l] != BG) begin
        rgb_d = rd_all[l];
        found = 1'b1;
      end
    end
    if (!von1_q) rgb_d = '0;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      raddr_q <= '0;
      von0_q  <= 1'b0;
      von1_q  <= 1'b0;
      show0_q <= '0;
      show1_q <= '0;
      rgb_q   <= '0;
    end else begin
      raddr_q <= raddr_d;
      von0_q  <= video_on;
      von1_q  <= von0_q;
      show0_q <= show_mask;
      show1_q <= show0_q;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb = rgb_q;
endmodule

// File: doc/multilayer_canvas.md
# multilayer_canvas

Parametrised paint-canvas engine for the VGA drawing design. It generalises the fixed three-layer BRAM scheme to NUM_LAYERS downscaled layer framebuffers and owns all writes to them. Writes come from a handshaked brush-stamp FSM and a hardware layer-clear sweep. A fixed-latency read pipeline composites the visible layers into the RGB stream. It sits between the VGA controller (x, y, video_on), the cursor/colour logic, and the rgb pins.

## Interface
- NUM_LAYERS, 3, number of layer framebuffers (1..8)
- COLOR_W, 3, bits per stored pixel
- H_RES / V_RES, 640 / 480, visible screen size
- SCALE, 2, screen pixels per canvas pixel per axis (power of two)
- BG, all ones, background/transparent colour (eraser value)
- Derived: CW=H_RES/SCALE (320), CH=V_RES/SCALE (240), DEPTH=CW*CH (76800), ADDR_W=clog2(DEPTH) (17)

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- video_on  in  1  from VGA controller
- x, y  in  10 each  current scan pixel
- brush_valid  in  1  stamp request
- brush_ready  out  1  stamp accepted when valid & ready
- brush_x, brush_y  in  10 each  screen-space top-left of stamp
- brush_size  in  2  side = 1<<brush_size canvas pixels (1, 2, 4, 8)
- brush_color  in  COLOR_W  value written
- brush_layer_mask  in  NUM_LAYERS  target layers
- clear_req  in  1  start clear sweep
- clear_layer_mask  in  NUM_LAYERS  layers to clear
- show_mask  in  NUM_LAYERS  layers included in composite
- busy  out  1  FSM not IDLE
- op_done  out  1  one-cycle pulse at end of PAINT or CLEAR
- rgb  out  COLOR_W  composited pixel, registered

## Operation
- Storage: NUM_LAYERS simple dual-port BRAMs of DEPTH x COLOR_W. Port A is sync read for the scan. Port B is write only. On a same-address collision, read-first: the scan sees old data.
- FSM states: CLEAR, IDLE, PAINT.
- Reset: enter CLEAR with mask = all ones and counter 0. Aborts any PAINT or CLEAR in progress.
- CLEAR: one address per cycle, 0..DEPTH-1. Writes BG to every layer whose bit is in the latched mask. After DEPTH-1 → IDLE, op_done pulses.
- IDLE:
  - clear_req has priority. Latch clear_layer_mask → CLEAR.
  - Otherwise, brush_valid → PAINT. Latch cx=brush_x/SCALE, cy=brush_y/SCALE, side, colour and mask.
- brush_ready = (state==IDLE) & ~clear_req & ~reset (combinational).
- PAINT: (dx, dy) raster, dx inner loop, one canvas pixel per cycle, exactly side² cycles.
  - Address = (cy+dy)*CW + (cx+dx), using ADDR_W-bit arithmetic.
  - A pixel with cx+dx ≥ CW or cy+dy ≥ CH is clipped: no write, but the cycle is still consumed. There is no wrap-around.
  - After the last pixel → IDLE, op_done pulses.
- clear_req or brush_valid outside IDLE is ignored, not queued.
- Empty target mask: FSM runs normally with no writes.
- Composite: scan the layers from the highest index to index 0. The first layer with show_mask set and pixel ≠ BG wins. If none wins, output BG.
- Blanking: rgb = 0 when the delayed video_on is low.

## Timing
- Read pipeline:
  - S0: register addr = (y/SCALE)*CW + x/SCALE, video_on, show_mask.
  - S1: BRAM read.
  - S2: composite into the rgb register.
- x/y/video_on sampled at cycle t appear on rgb at t+3. Latency is fixed and independent of FSM state.
- Write latency: a pixel written at cycle w is visible to a scan read whose S0 occurs at w+1 or later.
- Reset values: rgb=0, busy=1, brush_ready=0, op_done=0, pipeline valid=0.
- Full clear: busy high for DEPTH cycles after reset deasserts.
- Paint: busy high for side² cycles after acceptance. op_done is high in the cycle busy falls.
- Throughput: one write per cycle. Back-to-back stamps are separated by at least one IDLE cycle.

## Test plan
- Reset then release: busy high for exactly 76800 cycles, op_done pulses once. Every scanned visible pixel then gives rgb=3'b111, and rgb=0 during blanking.
- Stamp at (100,50), size 0, colour 3'b100, mask 3'b010, show 3'b111: one write to layer 1 at addr 8050. Screen pixels (100..101, 50..51) give rgb=3'b100, 3 cycles after x/y; neighbours stay 3'b111.
- Priority: layer 0 painted 3'b100, then layer 2 painted 3'b001 at the same pixel.
  - show_mask 3'b111 → 3'b001.
  - show_mask 3'b011 → 3'b100.
  - show_mask 3'b000 → 3'b111.
- Clipping: size 3 at (636,476) → cx=318, cy=238. Exactly 4 writes (addresses 76478, 76479, 76798, 76799), busy for 64 cycles, and no write to low addresses.
- In IDLE, clear_req and brush_valid asserted in the same cycle: brush_ready=0, CLEAR is entered, and the stamp is not performed. A clear_req during PAINT is ignored and PAINT completes.
- Reset asserted mid-PAINT (cycle 10 of 64): the stamp aborts, busy stays high, and a full 76800-cycle clear of all layers follows. Afterwards all pixels are BG.
